// File: rtl/seq_calculator.sv
// ---------------------------------------------------------------------------
// seq_calculator
//   Multi-cycle unsigned calculator with valid/ready handshakes on both sides.
//   ADD, SUB and MUL finish in a single execute cycle. DIV with a nonzero
//   divisor runs a restoring divider for WIDTH cycles, one quotient bit per
//   cycle, MSB first. DIV by zero takes the execute path and returns a fixed
//   answer. Only one command is in flight at a time; nothing is pipelined.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   in_valid     command present on op/a/b
//   in_ready     high only while idle; a command is accepted on
//                in_valid && in_ready at a rising edge
//   op           00 ADD, 01 SUB, 10 MUL, 11 DIV
//   a, b         unsigned operands, captured on acceptance
//   out_valid    result and flags are valid; they hold until the handshake
//   out_ready    consumer takes the result on out_valid && out_ready
//   result       sum, difference, low half of product, or quotient
//   remainder    DIV remainder, 0 for the other ops
//   carry        ADD carry-out, SUB borrow, MUL overflow; 0 for DIV
//   div_by_zero  DIV with b == 0
// ---------------------------------------------------------------------------
module seq_calculator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             carry,
    output logic             div_by_zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam int         CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // quo_q/rem_q double as the divider working registers and as the holding
    // place for the finished answer until it is copied to the output stage.
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               carry_p_q, carry_p_d;
    logic               dbz_p_q, dbz_p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               carry_q, carry_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH:0]     shifted_w;
    logic [WIDTH:0]     trial_w;

    assign sum_w     = {1'b0, a_q} + {1'b0, b_q};
    // Top bit of the zero-extended difference is the borrow (a < b).
    assign diff_w    = {1'b0, a_q} - {1'b0, b_q};
    assign prod_w    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    // Restoring step: bring the next dividend bit into the partial remainder
    // and try subtracting the divisor; no borrow means the quotient bit is 1.
    assign shifted_w = {rem_q, quo_q[WIDTH-1]};
    assign trial_w   = shifted_w - {1'b0, b_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            carry_p_q   <= 1'b0;
            dbz_p_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            carry_p_q   <= carry_p_d;
            dbz_p_q     <= dbz_p_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            carry_q     <= carry_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        carry_p_d   = carry_p_q;
        dbz_p_d     = dbz_p_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        carry_d     = carry_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = op;
                    a_d       = a;
                    b_d       = b;
                    carry_p_d = 1'b0;
                    dbz_p_d   = 1'b0;
                    if (op == OP_DIV && b != '0) begin
                        quo_d   = a;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                rem_d = '0;
                unique case (op_q)
                    OP_ADD: begin
                        quo_d     = sum_w[WIDTH-1:0];
                        carry_p_d = sum_w[WIDTH];
                    end
                    OP_SUB: begin
                        quo_d     = diff_w[WIDTH-1:0];
                        carry_p_d = diff_w[WIDTH];
                    end
                    OP_MUL: begin
                        quo_d     = prod_w[WIDTH-1:0];
                        carry_p_d = |prod_w[2*WIDTH-1:WIDTH];
                    end
                    default: begin
                        // Only a zero divisor reaches EXEC with DIV.
                        quo_d   = '1;
                        rem_d   = a_q;
                        dbz_p_d = 1'b1;
                    end
                endcase
                state_d = S_DONE;
            end

            S_DIV: begin
                if (!trial_w[WIDTH]) begin
                    rem_d = trial_w[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted_w[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // First DONE cycle loads the registered output stage; after
                // that the outputs hold until the consumer takes them.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    result_d    = quo_q;
                    remainder_d = rem_q;
                    carry_d     = carry_p_q;
                    dbz_d       = dbz_p_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign remainder   = remainder_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;

endmodule
